// File: rtl/fetch_stage_pkg.sv
// Shared widths and constants for the instruction-fetch stage.
// Module parameters default to these values.
package fetch_stage_pkg;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_QUEUE_DEPTH = 2;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;

    typedef logic epoch_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and memory (slave).
// A request transfers on a cycle with imem_req_valid && imem_req_ready; valid may
// drop without a transfer. Responses are unconditional, in order, one per request.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with clear, same-cycle push+pop (also when full) and
// a per-entry kill flag that can be set on every stored entry at once.
module fetch_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             clear,
    input  logic             kill_all,
    output logic [WIDTH-1:0] head,
    output logic             head_kill,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] kill;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head      = mem[rd_ptr];
    assign head_kill = kill[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            kill   <= '0;
        end else begin
            if (kill_all) kill <= '1;
            // A push in the kill cycle is newer than the kill and stays live.
            if (do_push) begin
                kill[wr_ptr] <= 1'b0;
                wr_ptr       <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues credit-limited word fetches and
// buffers returned {pc,instr} for decode, dropping wrong-path responses by epoch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC),
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_stage_if.master          imem,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   stall,
    output logic                   id_valid,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [INSTR_WIDTH-1:0] id_instr
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int IF_W  = ADDR_WIDTH + 1;
    localparam int DQ_W  = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    epoch_t                epoch;
    logic                  issue;
    logic                  rsp_take;
    logic                  tag_live;
    logic                  dq_push;
    logic                  dq_pop;
    logic [IF_W-1:0]       if_head;
    logic                  if_kill;
    logic                  if_empty;
    logic                  if_full_unused;
    logic [CNT_W-1:0]      out_cnt;
    logic [DQ_W-1:0]       dq_head;
    logic                  dq_kill_unused;
    logic                  dq_empty;
    logic                  dq_full_unused;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W:0]        credit_use;

    // Every in-flight request owns a reserved queue slot, so the queue never overflows.
    assign credit_use          = {1'b0, out_cnt} + {1'b0, occ};
    assign imem.imem_req_valid = reset && !redirect_valid &&
                                 (credit_use < (CNT_W + 1)'(QUEUE_DEPTH));
    assign imem.imem_req_addr  = fetch_pc;
    assign issue               = imem.imem_req_valid && imem.imem_req_ready;

    assign rsp_take = imem.imem_rsp_valid && !if_empty;
    assign tag_live = !if_kill && (if_head[0] == epoch) && !redirect_valid;
    assign dq_push  = rsp_take && tag_live;
    assign dq_pop   = !dq_empty && !stall && !redirect_valid;

    assign id_valid = !dq_empty;
    assign id_pc    = dq_empty ? '0 : dq_head[DQ_W-1 -: ADDR_WIDTH];
    assign id_instr = dq_empty ? '0 : dq_head[INSTR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            epoch    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);
            epoch    <= ~epoch;
        end else if (issue) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        end
    end

    // In-flight tracker: {pc, epoch} per request, killed wholesale on redirect.
    fetch_queue #(.WIDTH(IF_W), .DEPTH(QUEUE_DEPTH)) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .wdata     ({fetch_pc, epoch}),
        .pop       (rsp_take),
        .clear     (1'b0),
        .kill_all  (redirect_valid),
        .head      (if_head),
        .head_kill (if_kill),
        .full      (if_full_unused),
        .empty     (if_empty),
        .count     (out_cnt)
    );

    fetch_queue #(.WIDTH(DQ_W), .DEPTH(QUEUE_DEPTH)) u_decode_q (
        .clk       (clk),
        .reset     (reset),
        .push      (dq_push),
        .wdata     ({if_head[IF_W-1:1], imem.imem_rsp_data}),
        .pop       (dq_pop),
        .clear     (redirect_valid),
        .kill_all  (1'b0),
        .head      (dq_head),
        .head_kill (dq_kill_unused),
        .full      (dq_full_unused),
        .empty     (dq_empty),
        .count     (occ)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural in-order instruction memory
// whose data for address a is a ^ MAGIC.
module tb_fetch_stage;
    localparam logic [31:0] MAGIC = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        rsp_en;
    logic [31:0] pend_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    // Memory: latency 1 when rsp_en, otherwise responses are held back.
    always @(posedge clk) begin
        if (imem_bus.imem_req_valid && imem_bus.imem_req_ready)
            pend_q.push_back(imem_bus.imem_req_addr);
        if (rsp_en && pend_q.size() != 0) begin
            imem_bus.imem_rsp_valid <= 1'b1;
            imem_bus.imem_rsp_data  <= pend_q.pop_front() ^ MAGIC;
        end else begin
            imem_bus.imem_rsp_valid <= 1'b0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for decode to consume an instruction, then check it.
    task automatic expect_id(input logic [31:0] pc);
        int n = 0;
        #1;
        while (!(id_valid && !stall) && n < 20) begin
            next_cycle();
            #1;
            n++;
        end
        chk("id_wait", 32'(id_valid && !stall), 32'd1);
        chk("id_pc", id_pc, pc);
        chk("id_instr", id_instr, pc ^ MAGIC);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        stall = 1'b0;
        rsp_en = 1'b1;
        imem_bus.imem_req_ready = 1'b1;

        // Held in reset
        repeat (3) next_cycle();
        #1;
        chk("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);

        // Release: first fetches and first-instruction latency
        next_cycle();
        reset = 1'b1;
        #1;
        chk("c0_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
        chk("c0_req_addr", imem_bus.imem_req_addr, 32'h0);
        next_cycle();
        #1;
        chk("c1_req_addr", imem_bus.imem_req_addr, 32'h4);
        chk("c1_id_valid", 32'(id_valid), 32'd0);
        next_cycle();
        #1;
        chk("c2_id_valid", 32'(id_valid), 32'd1);
        chk("c2_id_pc", id_pc, 32'h0);
        chk("c2_id_instr", id_instr, 32'hDEAD_0000);
        chk("c2_no_credit", 32'(imem_bus.imem_req_valid), 32'd0);
        next_cycle();
        #1;
        chk("c3_id_pc", id_pc, 32'h4);
        chk("c3_req_addr", imem_bus.imem_req_addr, 32'h8);
        next_cycle();
        expect_id(32'h8);
        expect_id(32'hC);

        // Stall until the queue fills and credits run out
        stall = 1'b1;
        repeat (6) next_cycle();
        #1;
        chk("stall_id_valid", 32'(id_valid), 32'd1);
        chk("stall_id_pc", id_pc, 32'h10);
        chk("stall_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        chk("stall_req_addr", imem_bus.imem_req_addr, 32'h18);
        next_cycle();
        #1;
        chk("stall_id_pc_held", id_pc, 32'h10);
        stall = 1'b0;
        expect_id(32'h10);
        expect_id(32'h14);
        expect_id(32'h18);
        expect_id(32'h1C);

        // Redirect to 0x100 with two requests in flight
        rsp_en = 1'b0;
        repeat (6) next_cycle();
        #1;
        chk("inflight_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        chk("inflight_id_valid", 32'(id_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("redir_blocks_req", 32'(imem_bus.imem_req_valid), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        rsp_en = 1'b1;
        #1;
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        chk("redir_req_addr", imem_bus.imem_req_addr, 32'h100);
        expect_id(32'h100);
        expect_id(32'h104);

        // Unaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk("align_req_addr", imem_bus.imem_req_addr, 32'h200);
        chk("align_id_valid", 32'(id_valid), 32'd0);
        expect_id(32'h200);
        expect_id(32'h204);

        // Back-to-back redirects: only the second path survives
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        next_cycle();
        redirect_pc = 32'h80;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk("b2b_req_addr", imem_bus.imem_req_addr, 32'h80);
        chk("b2b_id_valid", 32'(id_valid), 32'd0);
        expect_id(32'h80);
        expect_id(32'h84);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_req_addr", imem_bus.imem_req_addr, 32'hFFFF_FFFC);
        expect_id(32'hFFFF_FFFC);
        expect_id(32'h0);

        // Reset with two requests outstanding; responses land during reset
        rsp_en = 1'b0;
        repeat (6) next_cycle();
        #1;
        chk("pre_rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        reset = 1'b0;
        rsp_en = 1'b1;
        repeat (4) next_cycle();
        #1;
        chk("mid_rst_id_valid", 32'(id_valid), 32'd0);
        chk("mid_rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        chk("mid_rst_id_pc", id_pc, 32'h0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("post_rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_bus.imem_req_addr, 32'h0);
        expect_id(32'h0);
        expect_id(32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
